// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer: fetches a word at pc, presents the opcode
// fields for one decode cycle, then advances or loads pc, or halts.
module instr_sequencer #(
    parameter int unsigned       ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [15:0]       memData,
    output logic              insMode,
    output logic [2:0]        insShort,
    output logic [3:0]        insLong,
    output logic [11:0]       operand,
    output logic              exeValid,
    input  logic              stop,
    input  logic              pcWR,
    input  logic              accNeg,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] ir;
    logic              jump_taken_c;

    // Long-mode branches are conditional on a negative accumulator.
    assign jump_taken_c = pcWR & (~ir[15] | accNeg);

    // Every output below is a register or a fixed slice of one.
    assign memAddr  = pc;
    assign insMode  = ir[15];
    assign insShort = ir[14:12];
    assign insLong  = ir[15:12];
    assign operand  = ir[11:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            memReq   <= 1'b0;
            exeValid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state  <= S_FETCH;
                        memReq <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (memAck) begin
                        ir       <= memData;
                        state    <= S_EXEC;
                        memReq   <= 1'b0;
                        exeValid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    exeValid <= 1'b0;
                    if (stop) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_FETCH;
                        memReq <= 1'b1;
                        pc     <= jump_taken_c ? ADDR_W'(ir[11:0]) : pc + ADDR_W'(1);
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed cases plus randomized
// instruction streams checked against a transaction-level pc/IR model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        memReq;
    logic [11:0] memAddr;
    logic        memAck = 1'b0;
    logic [15:0] memData = 16'h0000;
    logic        insMode;
    logic [2:0]  insShort;
    logic [3:0]  insLong;
    logic [11:0] operand;
    logic        exeValid;
    logic        stop = 1'b0;
    logic        pcWR = 1'b0;
    logic        accNeg = 1'b0;
    logic [11:0] pc;
    logic        halted;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_pc;
    logic [15:0] exp_ir;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData),
        .insMode(insMode), .insShort(insShort), .insLong(insLong), .operand(operand),
        .exeValid(exeValid), .stop(stop), .pcWR(pcWR), .accNeg(accNeg),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag);
        check({tag, "_mode"},  32'(insMode),  32'(exp_ir[15]));
        check({tag, "_short"}, 32'(insShort), 32'(exp_ir[14:12]));
        check({tag, "_long"},  32'(insLong),  32'(exp_ir[15:12]));
        check({tag, "_opnd"},  32'(operand),  32'(exp_ir[11:0]));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},    32'(memReq),   32'd0);
        check({tag, "_exe"},    32'(exeValid), 32'd0);
        check({tag, "_halted"}, 32'(halted),   32'd0);
        check({tag, "_pc"},     32'(pc),       32'(exp_pc));
        check_fields(tag);
    endtask

    task automatic do_reset();
        run = 1'b0; memAck = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_pc = 12'h000;
        exp_ir = 16'h0000;
        check_idle("reset");
    endtask

    task automatic idle_ack();
        memAck = 1'b1; memData = 16'hBEEF;
        tick();
        memAck = 1'b0;
        check_idle("idle_ack");
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
        check("start_req",  32'(memReq),  32'd1);
        check("start_addr", 32'(memAddr), 32'(exp_pc));
        check("start_exe",  32'(exeValid), 32'd0);
    endtask

    task automatic wait_fetch(input int dly);
        for (int i = 0; i < dly; i++) begin
            memAck = 1'b0;
            run = 1'($urandom);
            tick();
            check("wait_req",  32'(memReq),   32'd1);
            check("wait_addr", 32'(memAddr),  32'(exp_pc));
            check("wait_exe",  32'(exeValid), 32'd0);
        end
        run = 1'b0;
    endtask

    // One fetch/execute transaction; the bench plays memory and decoder.
    task automatic exec_instr(input logic [15:0] data, input logic stp, input logic pw,
                              input logic neg, input int dly, input logic junk);
        wait_fetch(dly);
        memAck = 1'b1; memData = data;
        tick();
        memAck = 1'b0; memData = 16'($urandom);
        exp_ir = data;
        check("exec_strobe", 32'(exeValid), 32'd1);
        check("exec_req",    32'(memReq),   32'd0);
        check_fields("exec");
        stop = stp; pcWR = pw; accNeg = neg; memAck = junk;
        tick();
        stop = 1'b0; pcWR = 1'b0; accNeg = 1'b0; memAck = 1'b0;
        if (stp) begin
            check("halt_flag", 32'(halted),   32'd1);
            check("halt_req",  32'(memReq),   32'd0);
            check("halt_exe",  32'(exeValid), 32'd0);
            check("halt_pc",   32'(pc),       32'(exp_pc));
        end else begin
            if (pw && (!data[15] || neg)) exp_pc = data[11:0];
            else                          exp_pc = exp_pc + 12'd1;
            check("next_req",  32'(memReq),   32'd1);
            check("next_addr", 32'(memAddr),  32'(exp_pc));
            check("next_exe",  32'(exeValid), 32'd0);
            check("next_halt", 32'(halted),   32'd0);
            check_fields("ir_hold");
        end
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b1; memAck = 1'($urandom); memData = 16'($urandom);
            tick();
            check("hold_flag", 32'(halted),   32'd1);
            check("hold_req",  32'(memReq),   32'd0);
            check("hold_exe",  32'(exeValid), 32'd0);
            check("hold_pc",   32'(pc),       32'(exp_pc));
            check_fields("hold");
        end
        run = 1'b0; memAck = 1'b0;
    endtask

    // Reset lands mid-fetch together with memAck; the fetch must be dropped.
    task automatic abort_fetch(input int dly);
        wait_fetch(dly);
        rst_n = 1'b0; memAck = 1'b1; memData = 16'($urandom);
        tick();
        rst_n = 1'b1; memAck = 1'b0;
        exp_pc = 12'h000;
        exp_ir = 16'h0000;
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_req", 32'(memReq),   32'd0);
            check("abort_exe", 32'(exeValid), 32'd0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic        s;
        tick();
        do_reset();
        idle_ack();
        start();
        exec_instr(16'h2005, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(16'h5123, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        exec_instr(16'hC040, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        exec_instr(16'hC040, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        exec_instr(16'h7ABC, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        exec_instr(16'h5FFF, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        exec_instr(16'h2001, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        exec_instr(16'h1234, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        exec_instr(16'hF000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        halt_hold(10);
        do_reset();
        start();
        abort_fetch(5);
        start();
        exec_instr(16'h3001, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            d = 16'($urandom);
            s = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) begin
                abort_fetch($urandom_range(0, 3));
                start();
            end else begin
                exec_instr(d, s, 1'($urandom), 1'($urandom),
                           $urandom_range(0, 3), 1'($urandom));
                if (s) begin
                    halt_hold(3);
                    do_reset();
                    start();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter RESET_PC, default 12'h000, is the PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 12, is the PC and memory-address width; only 12 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 run  input  1  start request; leaves IDLE when sampled high.
REQ-006 memReq  output  1  instruction-fetch request.
REQ-007 memAddr  output  12  fetch address; equals pc while memReq=1.
REQ-008 memAck  input  1  fetch completion; memData valid in the same cycle.
REQ-009 memData  input  16  instruction word: [15] mode, [15:12] long opcode, [14:12] short opcode, [11:0] operand.
REQ-010 insMode / insShort / insLong  output  1/3/4  IR[15], IR[14:12], IR[15:12]; these drive the control-unit decoder.
REQ-011 operand  output  12  IR[11:0].
REQ-012 exeValid  output  1  one-cycle strobe; opcode fields are valid and the decoder outputs are sampled in this cycle.
REQ-013 stop, pcWR  input  1 each  decoder outputs for the current IR.
REQ-014 accNeg  input  1  accumulator sign bit; qualifies the long-mode conditional branch.
REQ-015 pc  output  12  current program counter.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, HALT, and nothing else.
REQ-018 IDLE: memReq=0 and exeValid=0; if run=1 -> FETCH on the next edge.
REQ-019 FETCH: memReq=1 and memAddr=pc, held stable until memAck=1.
REQ-020 FETCH with memAck=1: IR<=memData, -> EXEC; memReq deasserts in the following cycle.
REQ-021 memAck outside FETCH SHALL be ignored, with no IR or state change.
REQ-022 EXEC lasts exactly one cycle with exeValid=1; IR SHALL NOT change during EXEC.
REQ-023 EXEC with stop=1 -> HALT; pc unchanged; stop takes priority over pcWR.
REQ-024 Jump taken = pcWR & (insMode==0 | accNeg).
REQ-025 EXEC, no stop, jump taken: pc<=operand, -> FETCH.
REQ-026 EXEC, no stop, jump not taken: pc<=pc+1 modulo 2^12, so 12'hFFF wraps to 12'h000; -> FETCH.
REQ-027 HALT: halted=1, memReq=0, exeValid=0; the block stays in HALT regardless of run or memAck; only reset exits.
REQ-028 Fetch-to-fetch latency: with memAck in the first FETCH cycle, the next memReq rises 2 cycles after the previous memReq rose.
REQ-029 An undecodable opcode (stop=0, pcWR=0) SHALL be treated as not-taken, so pc increments.

Reset
REQ-030 rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, IR=16'h0000, memReq=0, exeValid=0, halted=0.
REQ-031 Reset SHALL take precedence over every other input, in every state, including mid-FETCH with memAck=1 in the same cycle.
REQ-032 A fetch interrupted by reset SHALL be abandoned and SHALL NOT be reissued until run=1.

Verification
REQ-033 Reset, run=1, memAck in the first FETCH cycle with memData=16'h2005 (lda 5) -> memAddr=000, exeValid pulses once, insShort=010, operand=005, next memAddr=001.
REQ-034 memData=16'h5123 (jmp), pcWR=1 -> next memAddr=123.
REQ-035 memData=16'hC040 (ban), pcWR=1: accNeg=0 -> pc+1; accNeg=1 -> pc=040.
REQ-036 memData=16'hF000 (stp), stop=1 -> halted=1, memReq stays 0 for at least 10 cycles with run=1; rst_n=0 -> halted=0, pc=000.
REQ-037 pc=FFF, non-jump instruction -> next memAddr=000.
REQ-038 memAck delayed 5 cycles -> memReq and memAddr stable throughout the wait; rst_n=0 during the wait -> IDLE with no EXEC strobe.
